// File: rtl/ripple_cap_pkg.sv
// Shared types and constants for the ripple counter capture block.
package ripple_cap_pkg;

  localparam int CNT_W     = 4;
  localparam int DELTA_W   = 8;
  localparam int DELTA_MAX = 255;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    PEND
  } cap_state_t;

  // Forward distance between two counter readings, wrapping modulo 16.
  function automatic logic [CNT_W-1:0] wrap_delta(input logic [CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0] prev);
    return cur - prev;
  endfunction

endpackage

// File: rtl/ripple_sample_filter.sv
// Synchronizes the ripple counter bits and only passes on values that have
// held still long enough for every bit to have settled.
module ripple_sample_filter
  import ripple_cap_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             accept,
  output logic [CNT_W-1:0] acc_value,
  output logic [CNT_W-1:0] prev_value
);

  localparam logic [2:0] RUN_MAX = 3'(STABLE_CYCLES);

  logic [CNT_W-1:0] sync_meta;
  logic [CNT_W-1:0] sync_q;
  logic [CNT_W-1:0] stable;
  logic [2:0]       run;
  logic [2:0]       run_next;
  logic             primed;
  logic             take;

  // Run length of identical samples, plus the decision to take a new value.
  always_comb begin
    run_next = run;
    if (sync_meta != sync_q) begin
      run_next = 3'd1;
    end else if (run >= RUN_MAX) begin
      run_next = RUN_MAX;
    end else begin
      run_next = run + 3'd1;
    end
    take = (run_next == RUN_MAX) && (!primed || (sync_q != stable));
  end

  // Two-flop synchronizer; deliberately untouched by clr.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= cnt_in;
      sync_q    <= sync_meta;
    end
  end

  // Run counter keeps tracking the raw bits even across a clr.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run <= '0;
    end else begin
      run <= run_next;
    end
  end

  // Baseline register; the first value after reset or clr only primes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      primed     <= 1'b0;
      stable     <= '0;
      accept     <= 1'b0;
      acc_value  <= '0;
      prev_value <= '0;
    end else if (clr) begin
      primed <= 1'b0;
      accept <= 1'b0;
    end else begin
      accept <= take && primed;
      if (take) begin
        primed     <= 1'b1;
        stable     <= sync_q;
        acc_value  <= sync_q;
        prev_value <= stable;
      end
    end
  end

endmodule

// File: rtl/ripple_count_capture.sv
// Extends filtered ripple counter readings into a wide running count and
// hands snapshots of it to a consumer over a valid/ready handshake.
module ripple_count_capture
  import ripple_cap_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int EXT_WIDTH     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     cnt_in,
  input  logic                 en,
  input  logic                 clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXT_WIDTH-1:0] out_count,
  output logic [DELTA_W-1:0]   out_delta,
  output logic                 out_sat,
  output logic                 overflow
);

  logic                 accept;
  logic [CNT_W-1:0]     acc_value;
  logic [CNT_W-1:0]     prev_value;
  logic [CNT_W-1:0]     delta;
  logic                 accum;
  logic [EXT_WIDTH-1:0] ext_count;
  logic [EXT_WIDTH:0]   ext_sum;
  logic [DELTA_W-1:0]   pend;
  logic                 pend_sat;
  logic [DELTA_W:0]     pend_sum;
  logic [DELTA_W-1:0]   pend_next;
  logic                 sat_next;
  logic [EXT_WIDTH-1:0] cnt_cur;
  logic [DELTA_W-1:0]   pend_cur;
  logic                 sat_cur;
  logic                 load_snap;
  cap_state_t           state;
  cap_state_t           state_next;

  ripple_sample_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clock     (clock),
    .reset     (reset),
    .clr       (clr),
    .cnt_in    (cnt_in),
    .accept    (accept),
    .acc_value (acc_value),
    .prev_value(prev_value)
  );

  // Delta arithmetic and the "current" values a snapshot would capture.
  always_comb begin
    delta    = wrap_delta(acc_value, prev_value);
    accum    = accept && en && (delta != '0);
    ext_sum  = {1'b0, ext_count} + (EXT_WIDTH+1)'(delta);
    pend_sum = {1'b0, pend} + (DELTA_W+1)'(delta);
    sat_next = pend_sat || (pend_sum > (DELTA_W+1)'(DELTA_MAX));
    if (pend_sum > (DELTA_W+1)'(DELTA_MAX)) begin
      pend_next = DELTA_W'(DELTA_MAX);
    end else begin
      pend_next = pend_sum[DELTA_W-1:0];
    end
    cnt_cur  = accum ? ext_sum[EXT_WIDTH-1:0] : ext_count;
    pend_cur = accum ? pend_next : pend;
    sat_cur  = accum ? sat_next : pend_sat;
  end

  // Output FSM: decides when a fresh snapshot is loaded.
  always_comb begin
    state_next = state;
    load_snap  = 1'b0;
    case (state)
      IDLE: begin
        if (accum) begin
          state_next = HOLD;
          load_snap  = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready && accum) begin
          load_snap = 1'b1;
        end else if (out_ready) begin
          state_next = IDLE;
        end else if (accum) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (out_ready) begin
          state_next = HOLD;
          load_snap  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state != IDLE);

  // State register; clr forces the handshake back to idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Running count with a sticky wrap flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ext_count <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      ext_count <= '0;
      overflow  <= 1'b0;
    end else if (accum) begin
      ext_count <= ext_sum[EXT_WIDTH-1:0];
      if (ext_sum[EXT_WIDTH]) begin
        overflow <= 1'b1;
      end
    end
  end

  // Deltas not yet reported; emptied whenever a snapshot takes them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      pend_sat <= 1'b0;
    end else if (clr) begin
      pend     <= '0;
      pend_sat <= 1'b0;
    end else if (load_snap) begin
      pend     <= '0;
      pend_sat <= 1'b0;
    end else if (accum) begin
      pend     <= pend_next;
      pend_sat <= sat_next;
    end
  end

  // Snapshot registers stay frozen until the FSM asks for a reload.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_count <= '0;
      out_delta <= '0;
      out_sat   <= 1'b0;
    end else if (clr) begin
      out_count <= '0;
      out_delta <= '0;
      out_sat   <= 1'b0;
    end else if (load_snap) begin
      out_count <= cnt_cur;
      out_delta <= pend_cur;
      out_sat   <= sat_cur;
    end
  end

endmodule

// File: doc/ripple_count_capture.md
# ripple_count_capture

Captures the 4-bit output of the JK ripple counter into the system clock domain and extends it to a wide running count. The ripple bits settle at different times, so raw samples are not trusted. The block synchronizes the bits, then accepts a value only after it has been stable for a programmable number of cycles. It accumulates the modulo-16 deltas between accepted values and presents snapshots to a downstream consumer over a valid/ready handshake.

## Interface
- STABLE_CYCLES, 2, number of consecutive identical synchronized samples needed to accept a value; legal range 2..7
- EXT_WIDTH, 16, width of the extended running count; legal range 8..32
- clock  in  1  system clock; all flops are on the rising edge
- reset  in  1  asynchronous, active-low; all state clears on assertion
- cnt_in  in  4  raw ripple counter outputs q[3:0]; asynchronous to clock
- en  in  1  when 0, accepted values update the baseline only and no delta is counted
- clr  in  1  synchronous clear of count, pending delta and handshake; re-primes the baseline
- out_valid  out  1  snapshot available
- out_ready  in  1  consumer accepts the snapshot
- out_count  out  EXT_WIDTH  extended count at snapshot time
- out_delta  out  8  sum of deltas since the previous transfer; saturates at 255
- out_sat  out  1  out_delta saturated in this snapshot
- overflow  out  1  sticky flag; extended count wrapped past 2^EXT_WIDTH-1

## Operation
- Reset values: every output is 0. The filter is unprimed, the state is IDLE and the count is 0.
- Synchronizer: a 2-flop synchronizer per bit feeds sync_q.
- Stability filter:
  - run counter: resets to 1 when sync_q differs from the previous sample, otherwise increments and saturates at STABLE_CYCLES.
  - acceptance: a value is accepted when run reaches STABLE_CYCLES and differs from the stable register, or when the filter is unprimed.
- First acceptance after reset or clr: loads the baseline only, sets primed, and produces no delta.
- Delta: delta = (accepted - stable) mod 16, as 4-bit unsigned subtraction with wrap. Example: 14 to 1 gives 3.
  - The counter must advance fewer than 16 between acceptances. Aliasing beyond that is not detected.
- Accumulation (en=1, delta≠0):
  - ext_count += delta, modulo 2^EXT_WIDTH.
  - A carry out of the addition sets overflow. overflow clears only on reset or clr.
  - pend_delta += delta, saturating at 255, and a saturation flag is set.
- Output FSM:
  - IDLE: out_valid=0. Accumulation moves to HOLD, loading out_count=ext_count_next, out_delta=pend_next, out_sat, and clearing pend.
  - HOLD: out_valid=1, outputs frozen.
    - Accumulation without handshake moves to PEND.
    - Handshake without accumulation moves to IDLE.
    - Handshake with same-cycle accumulation reloads the snapshot and stays in HOLD.
  - PEND: out_valid=1, outputs frozen, pend keeps accumulating.
    - Handshake reloads the snapshot from current ext_count/pend (plus any same-cycle delta), clears pend, and moves to HOLD.
- Outputs never change while out_valid=1 and out_ready=0.
- clr: has priority over everything except reset.
  - Next cycle: out_valid=0, count=0, pend=0, overflow=0, unprimed, IDLE.
  - The synchronizer is not cleared.
- en=0: acceptances still update the stable register. No accumulation and no FSM transition occurs.
- Reset asserted mid-handshake: outputs drop to 0 immediately (asynchronous). No transfer is implied.

## Timing
- Consider a cnt_in value that is stable before edge N:
  - sync_q shows it after edge N+1.
  - It is accepted at edge N+STABLE_CYCLES.
  - out_valid and out_count update after edge N+STABLE_CYCLES+1. With default parameters that is 3 edges after N.
- A handshake occurs at a rising edge with out_valid=1 and out_ready=1. out_valid may stay 1 on the following cycle (PEND or same-cycle reload).
- out_ready may toggle freely. out_valid does not depend combinationally on out_ready.
- Throughput: one snapshot per cycle at most. Deltas are never lost, only merged into pend.

## Structure
- Shared package ripple_cap_pkg holds:
  - the state enum (IDLE, HOLD, PEND)
  - DELTA_W=8 and DELTA_MAX=255
  - CNT_W=4
- Sub-module ripple_sample_filter:
  - contains the synchronizer, run counter, stable register and primed flag.
  - outputs: accept pulse, accepted value, previous stable value.
- The top level holds accumulation, overflow and the output FSM.

## Test plan
- Reset, then cnt_in held at 5 for 10 cycles: baseline primes, out_valid stays 0, out_count=0.
- Baseline 5, cnt_in=9, out_ready=1: out_valid pulses 3 cycles after the change, with out_count=4 and out_delta=4.
- Glitch: cnt_in 9→13 for 1 cycle then back to 9: no acceptance and out_valid stays 0. Then 9→11 held: delta 2, out_count=6.
- Wrap: stable 14→1: delta 3. Preload the count near 2^16-1 (e.g. 65534) and apply delta 3: out_count=1 and overflow=1 (sticky).
- Backpressure: out_ready=0 while deltas 2, 3 and 4 arrive. The first snapshot stays frozen at delta 2. On ready, the next snapshot shows out_delta=7 and the latest count, then the FSM returns to IDLE.
- clr during PEND with out_ready=0: next cycle out_valid=0, count=0, overflow=0. The next accepted value primes only and produces no snapshot.
